hex8_scan: RTL
==============

# hex8_scan

Time-multiplexed scan controller for the 8-digit common-select seven-segment display. It stores a 32-bit hex value (8 nibbles) and an 8-bit per-digit blank mask, and steps through the digits at a fixed slot rate. On each step it drives the one-hot, active-high `sel` and presents the current digit's nibble on `key` for the existing hex-to-segment decoder. Display updates are double-buffered so that a new value only takes effect at a frame boundary, which prevents a torn frame.

## Interface
- `DIV`, 50000: clock cycles per digit slot. At 50 MHz this gives 1 kHz per digit and a 125 Hz frame. Constraint: `DIV >= BLANK_CYC + 2`.
- `BLANK_CYC`, 8: dead-time cycles at the start of each slot, during which `sel` = 0 (anti-ghosting). Constraint: `BLANK_CYC >= 0`.

- `clk`  in  1  system clock, 50 MHz.
- `reset_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  scan enable. 1 = scan; 0 = display off.
- `load`  in  1  single-cycle strobe that captures `disp_data` and `blank_mask` into the pending buffer.
- `disp_data`  in  32  digit k value = `disp_data[4k+3:4k]`; digit 0 is rightmost.
- `blank_mask`  in  8  bit k = 1 keeps digit k dark.
- `sel`  out  8  one-hot, active-high digit select; bit k = digit k.
- `key`  out  4  nibble of the current digit, fed to the segment decoder.
- `frame_done`  out  1  one-cycle pulse at each frame start.

## Operation
- Registers:
  - `cnt`: 0..DIV-1.
  - `digit`: 0..7.
  - `pend_data`/`pend_mask`/`pend_valid`: pending buffer.
  - `act_data`/`act_mask`: active buffer.
- Reset values:
  - All outputs are 0.
  - `cnt`, `digit`, `act_*`, `pend_*` and `pend_valid` are 0.
- Load:
  - `load` = 1 writes the pending buffer and sets `pend_valid`.
  - If `load` coincides with a transfer, the transfer uses the old pending contents, the new data lands in pending, and `pend_valid` stays 1.
- Transfer, active <= pending and `pend_valid` cleared:
  - Occurs on the edge where `digit` wraps 7->0.
  - While `en` = 0, it occurs on any edge where `pend_valid` = 1, so a load with the display off takes effect immediately.
- Scan, when `en` = 1:
  - `cnt` increments each cycle.
  - At `cnt` = DIV-1, `cnt` goes to 0 and `digit` advances by one, wrapping 7->0.
- Disabled, when `en` = 0:
  - `cnt` and `digit` are held at 0.
  - `sel` = 0.
  - `frame_done` = 0.
  - `key` = `act_data[3:0]`.
  - When `en` rises, the first slot is digit 0 starting from `cnt` = 0. This start does not pulse `frame_done`.
- Blank mask: a digit with its `act_mask` bit set never asserts `sel`. `key` still presents its nibble, and slot timing is unchanged.

## Timing
- All outputs are registered and computed from next-state values. No combinational path from inputs to outputs.
- Slot start for digit k: the edge where `cnt` loads 0 and `digit` loads k.
  - On that same edge, `key` updates to `act_data[4k+3:4k]`. The value is taken after any transfer on that edge.
  - On that same edge, `sel` goes to 0.
- `sel` asserts one-hot bit k on the edge where `cnt` becomes BLANK_CYC, unless masked. It stays high for DIV-BLANK_CYC cycles.
- `frame_done` is high for exactly the one cycle following the 7->0 wrap edge.
- Frame period = 8*DIV cycles.
- `en` falling: on the next edge `sel` = 0, `cnt` = 0 and `digit` = 0.
- `reset_n` low, including mid-slot: all registers clear immediately, without waiting for a clock edge. Scanning restarts at digit 0 on the first edge with `reset_n` = 1 and `en` = 1.
- `load` during `en` = 0 with `en` rising on the same edge: the transfer happens on that edge, and digit 0 shows the new data.

## Test plan
Parameters for all scenarios: DIV = 10, BLANK_CYC = 2.

1. Reset: assert `reset_n` = 0 mid-scan without a clock edge -> `sel` = 00, `key` = 0 and `frame_done` = 0 immediately. After release with `en` = 0 -> `sel` stays 00.
2. Basic scan: with `en` = 0, load `disp_data` = 32'h87654321 and `blank_mask` = 00, then set `en` = 1.
   - `key` steps 1,2,…,8, one value per 10 cycles.
   - `sel` steps 01,02,…,80. Each select is high for 8 cycles, preceded by 2 zero cycles.
   - `frame_done` pulses once every 80 cycles, starting at the second frame.
3. Double buffer: while digit 3 is showing, load 32'hFEDCBA98.
   - Digits 4..7 still show 5,6,7,8.
   - `frame_done` pulses.
   - Digit 0 then shows 8, digit 7 shows F.
4. Blank: `blank_mask` = F0 with `disp_data` = 32'h12345678.
   - `sel` only ever shows 01,02,04,08.
   - `key` still cycles through all 8 nibbles.
   - Frame period stays 80 cycles.
5. Load/wrap collision: pulse `load` with new data A on the 7->0 wrap edge while pending holds data B.
   - The frame starting at that edge shows B.
   - The next frame shows A.
6. Disable: drop `en` mid-slot of digit 5.
   - Next edge: `sel` = 00 and `key` = `act_data[3:0]`.
   - On re-enable, scanning restarts with digit 0 and `sel` = 01 after 2 cycles.

Source files
------------

// File: rtl/hex8_scan_if.sv
// Display-side bundle of the hex8_scan controller: update strobe/data in, digit drive out.
interface hex8_scan_if;
    logic        en;
    logic        load;
    logic [31:0] disp_data;
    logic [7:0]  blank_mask;
    logic [7:0]  sel;
    logic [3:0]  key;
    logic        frame_done;

    modport master (
        output en, load, disp_data, blank_mask,
        input  sel, key, frame_done
    );

    modport slave (
        input  en, load, disp_data, blank_mask,
        output sel, key, frame_done
    );
endinterface

// File: rtl/hex8_scan.sv
// Eight-digit multiplexed scan controller with a double-buffered value/blank mask.
// All outputs are registered from next-state values so nothing combinational reaches the pins.
module hex8_scan #(
    parameter int DIV       = 50000,
    parameter int BLANK_CYC = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    hex8_scan_if.slave  bus
);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       digit, digit_nxt;
    logic [31:0]      pend_data, act_data, act_data_nxt;
    logic [7:0]       pend_mask, act_mask, act_mask_nxt;
    logic             pend_valid, pend_valid_nxt;
    logic             run;
    logic             slot_end, frame_wrap, start, xfer;
    logic [7:0]       sel_nxt;
    logic [3:0]       key_nxt;

    function automatic logic [7:0] onehot(input logic [2:0] d);
        onehot = 8'd1 << d;
    endfunction

    always_comb begin
        slot_end   = bus.en && (cnt == CNT_W'(DIV - 1));
        frame_wrap = slot_end && (digit == 3'd7);
        // first scanning edge after en was low: pending content is committed here too
        start      = bus.en && !run;

        cnt_nxt   = '0;
        digit_nxt = '0;
        if (bus.en) begin
            cnt_nxt   = slot_end ? '0 : cnt + 1'b1;
            digit_nxt = slot_end ? digit + 3'd1 : digit;
        end

        xfer = pend_valid && (frame_wrap || !bus.en || start);

        act_data_nxt = act_data;
        act_mask_nxt = act_mask;
        if (start && bus.load) begin
            act_data_nxt = bus.disp_data;
            act_mask_nxt = bus.blank_mask;
        end else if (xfer) begin
            act_data_nxt = pend_data;
            act_mask_nxt = pend_mask;
        end

        pend_valid_nxt = pend_valid;
        if (bus.load) begin
            pend_valid_nxt = !start;
        end else if (xfer) begin
            pend_valid_nxt = 1'b0;
        end

        key_nxt = act_data_nxt[{digit_nxt, 2'b00} +: 4];
        sel_nxt = '0;
        if (bus.en && (cnt_nxt >= CNT_W'(BLANK_CYC)) && !act_mask_nxt[digit_nxt]) begin
            sel_nxt = onehot(digit_nxt);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt            <= '0;
            digit          <= '0;
            run            <= 1'b0;
            pend_data      <= '0;
            pend_mask      <= '0;
            pend_valid     <= 1'b0;
            act_data       <= '0;
            act_mask       <= '0;
            bus.sel        <= '0;
            bus.key        <= '0;
            bus.frame_done <= 1'b0;
        end else begin
            cnt            <= cnt_nxt;
            digit          <= digit_nxt;
            run            <= bus.en;
            pend_valid     <= pend_valid_nxt;
            act_data       <= act_data_nxt;
            act_mask       <= act_mask_nxt;
            if (bus.load) begin
                pend_data <= bus.disp_data;
                pend_mask <= bus.blank_mask;
            end
            bus.sel        <= sel_nxt;
            bus.key        <= key_nxt;
            bus.frame_done <= frame_wrap;
        end
    end
endmodule
